// File: rtl/bram_dma_pkg.sv
// Shared types and constants for the BRAM-to-DMA readback path.
package bram_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned ADDR_STEP      = 4;

endpackage

// File: rtl/bram_rd_fifo.sv
// Synchronous FIFO holding BRAM read data plus its last tag until the stream accepts it.
module bram_rd_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
            if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/bram_to_dma.sv
// Reads a contiguous word block from BRAM port A and streams it out as AXI4-Stream,
// issuing reads only when the output FIFO has room for every read in flight.
module bram_to_dma
    import bram_dma_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LEN_W      = 12,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [LEN_W-1:0]          len_words,
    output logic                      busy,
    output logic                      done,
    output logic                      clka,
    output logic                      rsta,
    output logic                      ena,
    output logic [ADDR_W-1:0]         addra,
    output logic [DATA_W-1:0]         dina,
    output logic [BYTES_PER_WORD-1:0] wea,
    input  logic [DATA_W-1:0]         douta,
    output logic [DATA_W-1:0]         m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 2);

    state_t              state;
    logic [ADDR_W-1:0]   cur_addr;
    logic [LEN_W-1:0]    remaining;
    logic [RD_LAT:0]     pipe_v;
    logic [RD_LAT:0]     pipe_l;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_empty;
    logic                fifo_full;
    logic                fifo_wr;
    logic [DATA_W:0]     fifo_rd_data;
    logic                pop;
    logic [OCC_W-1:0]    occ_next;
    logic                credit_ok;

    assign clka = clk;
    assign rsta = rst;
    assign dina = '0;
    assign wea  = '0;

    // Stage 0 of the read pipeline is the enable currently presented to the BRAM.
    assign ena = pipe_v[0];

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_rd_data[DATA_W-1:0];
    assign m_axis_tlast  = fifo_rd_data[DATA_W];
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign fifo_wr       = pipe_v[RD_LAT] && !fifo_full;

    // Occupancy seen next cycle before any new issue: buffered plus in flight, minus this pop.
    always_comb begin
        occ_next  = OCC_W'(fifo_count) + OCC_W'($countones(pipe_v)) - OCC_W'(pop);
        credit_ok = (occ_next < OCC_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            pipe_v    <= '0;
            pipe_l    <= '0;
            addra     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            pipe_v <= {pipe_v[RD_LAT-1:0], 1'b0};
            pipe_l <= {pipe_l[RD_LAT-1:0], 1'b0};
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_words == '0) begin
                            done <= 1'b1;
                        end else begin
                            // FIFO and pipeline are empty in IDLE, so the first read needs no credit check.
                            state     <= READ;
                            busy      <= 1'b1;
                            pipe_v[0] <= 1'b1;
                            pipe_l[0] <= (len_words == LEN_W'(1));
                            addra     <= base_addr;
                            cur_addr  <= base_addr + ADDR_W'(ADDR_STEP);
                            remaining <= len_words - LEN_W'(1);
                        end
                    end
                end
                READ: begin
                    if (remaining == '0) begin
                        state <= DRAIN;
                    end else if (credit_ok) begin
                        pipe_v[0] <= 1'b1;
                        pipe_l[0] <= (remaining == LEN_W'(1));
                        addra     <= cur_addr;
                        cur_addr  <= cur_addr + ADDR_W'(ADDR_STEP);
                        remaining <= remaining - LEN_W'(1);
                    end
                end
                DRAIN: begin
                    // Stay busy through the done cycle, then return to IDLE.
                    if (done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (pop && m_axis_tlast) begin
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    bram_rd_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data ({pipe_l[RD_LAT], douta}),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

endmodule

// File: tb/tb_bram_to_dma.sv
// Directed bench for bram_to_dma: a one-cycle-latency BRAM model feeds the DUT,
// a negedge monitor records enables, beats and done pulses relative to start.
module tb_bram_to_dma;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 12;
    localparam int unsigned RD_LAT = 1;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]  len_words = '0;
    logic              busy, done, clka, rsta, ena;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic [3:0]        wea;
    logic [DATA_W-1:0] douta = '0;
    logic [DATA_W-1:0] tdata;
    logic              tvalid, tlast;
    logic              tready = 1'b1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;
    bit rec = 1'b0;

    logic [31:0] ena_q[$];
    int          ena_cyc_q[$];
    logic [31:0] data_q[$];
    logic        last_q[$];
    int          beat_cyc_q[$];
    int          done_cyc_q[$];
    logic        busy_q[$];
    bit          any_tvalid;
    int          stall_err;
    int          max_occ;
    int          ovf;
    bit          stalled_prev;
    logic [31:0] prev_data;
    logic        prev_last;

    bram_to_dma #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
        .RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .len_words(len_words), .busy(busy), .done(done), .clka(clka),
        .rsta(rsta), .ena(ena), .addra(addra), .dina(dina), .wea(wea),
        .douta(douta), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
        .m_axis_tready(tready), .m_axis_tlast(tlast)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM contents: word at byte address a is 0x11 * (a/4 + 1), so 0,4,8,12 hold 0x11..0x44.
    function automatic logic [31:0] bram_word(input logic [31:0] a);
        return 32'(32'h11 * ((a >> 2) + 32'd1));
    endfunction

    always @(posedge clk) if (ena) douta <= bram_word(addra);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rec) begin
            busy_q.push_back(busy);
            if (ena) begin
                ena_q.push_back(addra);
                ena_cyc_q.push_back(cyc - t0);
            end
            if (tvalid && tready) begin
                data_q.push_back(tdata);
                last_q.push_back(tlast);
                beat_cyc_q.push_back(cyc - t0);
            end
            if (done) done_cyc_q.push_back(cyc - t0);
            if (tvalid) any_tvalid = 1'b1;
            if (stalled_prev && (!tvalid || tdata !== prev_data || tlast !== prev_last)) stall_err++;
            stalled_prev = tvalid && !tready;
            prev_data = tdata;
            prev_last = tlast;
            if (int'(dut.fifo_count) + $countones(dut.pipe_v) > max_occ)
                max_occ = int'(dut.fifo_count) + $countones(dut.pipe_v);
            if (dut.pipe_v[RD_LAT] && dut.fifo_full) ovf++;
        end
    end

    task automatic start_xfer(input logic [31:0] base, input logic [LEN_W-1:0] len);
        @(posedge clk); #1;
        ena_q.delete(); ena_cyc_q.delete(); data_q.delete(); last_q.delete();
        beat_cyc_q.delete(); done_cyc_q.delete(); busy_q.delete();
        any_tvalid = 1'b0; stall_err = 0; max_occ = 0; ovf = 0; stalled_prev = 1'b0;
        t0 = cyc;
        base_addr = base;
        len_words = len;
        start = 1'b1;
        rec = 1'b1;
    endtask

    task automatic run(input int n, input bit toggle, input int restart_at);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            start = (k == restart_at);
            if (k == restart_at) len_words = 12'd4;
            if (toggle) tready = ~tready;
        end
        start = 1'b0;
        tready = 1'b1;
        rec = 1'b0;
    endtask

    initial begin
        int nl;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ena", ena, 0);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_addra", addra, 0);
        rst = 1'b0;

        // Basic four-word transfer
        start_xfer(32'h0, 12'd4);
        run(12, 1'b0, 0);
        chk("t1_ena_count", ena_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_addr%0d", i), ena_q[i], 64'(4 * i));
            chk($sformatf("t1_ena_cyc%0d", i), ena_cyc_q[i], 64'(i + 1));
        end
        chk("t1_beat_count", data_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_data%0d", i), data_q[i], 64'(32'h11 * (i + 1)));
            chk($sformatf("t1_beat_cyc%0d", i), beat_cyc_q[i], 64'(i + 3));
            chk($sformatf("t1_last%0d", i), last_q[i], (i == 3) ? 64'd1 : 64'd0);
        end
        chk("t1_done_count", done_cyc_q.size(), 1);
        chk("t1_done_cyc", done_cyc_q[0], 7);
        chk("t1_busy_c0", busy_q[0], 0);
        chk("t1_busy_c1", busy_q[1], 1);
        chk("t1_busy_c7", busy_q[7], 1);
        chk("t1_busy_c8", busy_q[8], 0);

        // Backpressure: tready alternates every cycle
        start_xfer(32'h40, 12'd8);
        run(40, 1'b1, 0);
        chk("t2_beat_count", data_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_data%0d", i), data_q[i], 64'(32'h121 + 32'h11 * i));
            chk($sformatf("t2_last%0d", i), last_q[i], (i == 7) ? 64'd1 : 64'd0);
        end
        chk("t2_stall_stable", stall_err, 0);
        chk("t2_occ_le_depth", (max_occ <= DEPTH), 1);
        chk("t2_full_write", ovf, 0);
        chk("t2_done_count", done_cyc_q.size(), 1);

        // Zero length
        start_xfer(32'h20, 12'd0);
        run(6, 1'b0, 0);
        chk("t3_done_count", done_cyc_q.size(), 1);
        chk("t3_done_cyc", done_cyc_q[0], 1);
        chk("t3_ena_count", ena_q.size(), 0);
        chk("t3_tvalid_seen", any_tvalid, 0);
        nl = 0;
        foreach (busy_q[i]) nl += int'(busy_q[i]);
        chk("t3_busy_cycles", nl, 0);

        // Single word, with a second start pulsed while busy
        start_xfer(32'h8, 12'd1);
        run(14, 1'b0, 2);
        chk("t4_ena_count", ena_q.size(), 1);
        chk("t4_beat_count", data_q.size(), 1);
        chk("t4_data", data_q[0], 32'h33);
        chk("t4_last", last_q[0], 1);
        chk("t4_done_count", done_cyc_q.size(), 1);
        chk("t4_done_cyc", done_cyc_q[0], 4);

        // Reset mid-transfer, then a clean restart
        start_xfer(32'h0, 12'd16);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 40 && data_q.size() < 3; k++) begin
            @(negedge clk); #1;
        end
        chk("t5_three_beats", data_q.size(), 3);
        rec = 1'b0;
        rst = 1'b1;
        #1;
        chk("t5_rst_tvalid", tvalid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_ena", ena, 0);
        nl = 0;
        foreach (last_q[i]) nl += int'(last_q[i]);
        chk("t5_no_partial_last", nl, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        start_xfer(32'h100, 12'd2);
        run(12, 1'b0, 0);
        chk("t5_ena_count", ena_q.size(), 2);
        chk("t5_addr0", ena_q[0], 32'h100);
        chk("t5_addr1", ena_q[1], 32'h104);
        chk("t5_beat_count", data_q.size(), 2);
        chk("t5_data0", data_q[0], 32'h451);
        chk("t5_data1", data_q[1], 32'h462);
        chk("t5_last0", last_q[0], 0);
        chk("t5_last1", last_q[1], 1);

        // Address wrap at the top of the byte-address space
        start_xfer(32'hFFFF_FFFC, 12'd2);
        run(12, 1'b0, 0);
        chk("t6_ena_count", ena_q.size(), 2);
        chk("t6_addr0", ena_q[0], 32'hFFFF_FFFC);
        chk("t6_addr1", ena_q[1], 32'h0);
        chk("t6_beat_count", data_q.size(), 2);
        chk("t6_data0", data_q[0], 32'h4000_0000);
        chk("t6_data1", data_q[1], 32'h11);
        chk("t6_last0", last_q[0], 0);
        chk("t6_last1", last_q[1], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
